mem_requester: RTL

//  Initiator side of the Memory valid/ready interface (in_* write channel, out_* read channel).

---
 rtl/mem_requester.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_requester.sv
// Single-outstanding load/store initiator for the Memory valid/ready ports.
// Sub-word stores are performed as a read-modify-write of the enclosing aligned word.
module mem_requester #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [31:0] in_addr,
    output logic [31:0] in_data,
    output logic        in_valid,
    input  logic        in_ready,
    output logic [31:0] out_addr,
    input  logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_error_q, resp_error_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic [31:0]   in_addr_q, in_addr_d;
    logic [31:0]   in_data_q, in_data_d;
    logic          in_valid_q, in_valid_d;
    logic [31:0]   out_addr_q, out_addr_d;
    logic          out_valid_q, out_valid_d;

    logic [31:0]   lane, ext, merged;
    logic          stall, expired, req_bad;

    always_comb begin
        lane = out_data >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext = {{24{signed_q & lane[7]}}, lane[7:0]};
            2'd1:    ext = {{16{signed_q & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase

        merged = out_data;
        for (int unsigned i = 0; i < 4; i++) begin
            if ((size_q == 2'd0 && off_q == 2'(i)) || (size_q == 2'd1 && off_q[1] == i[1])) begin
                merged[8*i +: 8] = (size_q == 2'd1 && i[0]) ? wdata_q[15:8] : wdata_q[7:0];
            end
        end
    end

    assign req_bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);

    // Counter restarts on every state change because leaving a state always ends a stall run.
    assign stall   = ((state_q == S_RD || state_q == S_RMW_RD) && !out_ready) ||
                     (state_q == S_WR && !in_ready);
    assign expired = stall && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = (stall && !expired) ? cnt_q + CW'(1) : '0;
        off_d       = off_q;
        size_d      = size_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        in_addr_d   = in_addr_q;
        in_data_d   = in_data_q;
        out_addr_d  = out_addr_q;
        resp_data_d = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d      = req_addr[1:0];
                    size_d     = req_size;
                    signed_d   = req_signed;
                    wdata_d    = req_wdata;
                    in_addr_d  = {req_addr[31:2], 2'b00};
                    out_addr_d = {req_addr[31:2], 2'b00};
                    in_data_d  = req_wdata;
                    if (req_bad)                   state_d = S_ERR;
                    else if (!req_write)           state_d = S_RD;
                    else if (req_size == 2'd2)     state_d = S_WR;
                    else                           state_d = S_RMW_RD;
                end
            end
            S_RD: begin
                if (out_ready) begin
                    resp_data_d = ext;
                    state_d     = S_RESP;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_RMW_RD: begin
                if (out_ready) begin
                    in_data_d = merged;
                    state_d   = S_WR;
                end else if (expired) begin
                    state_d = S_ERR;
                end
            end
            S_WR: begin
                if (in_ready)     state_d = S_RESP;
                else if (expired) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d  = (state_d == S_IDLE);
        out_valid_d  = (state_d == S_RD) || (state_d == S_RMW_RD);
        in_valid_d   = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP) || (state_d == S_ERR);
        resp_error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
            in_addr_q    <= '0;
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            out_addr_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
            in_addr_q    <= in_addr_d;
            in_data_q    <= in_data_d;
            in_valid_q   <= in_valid_d;
            out_addr_q   <= out_addr_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_data  = resp_data_q;
    assign in_addr    = in_addr_q;
    assign in_data    = in_data_q;
    assign in_valid   = in_valid_q;
    assign out_addr   = out_addr_q;
    assign out_valid  = out_valid_q;

endmodule
